// File: rtl/fft_pkg.sv
// Shared FFT definitions: sizes, reader FSM states and the bank/row address mapping
// used by both the stage controller and the result reader.
package fft_pkg;

   localparam int N_LOG2 = 6;
   localparam int DW     = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } fft_rd_state_e;

   // Bank parity keeps butterfly partners in opposite banks.
   function automatic logic bank_of(input logic [N_LOG2-1:0] addr);
      return ^addr;
   endfunction

   function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] k);
      logic [N_LOG2-1:0] r;
      r = '0;
      for (int i = 0; i < N_LOG2; i++) begin
         r[i] = k[N_LOG2-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_result_reader_fifo.sv
// Two-entry output FIFO holding sample data and its frequency index; the head
// entry is a register that drives the stream outputs directly.
module fft_out_fifo #(
   parameter int DATA_W = fft_pkg::DW,
   parameter int IDX_W  = fft_pkg::N_LOG2
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic [IDX_W-1:0]  push_index,
   input  logic              pop,
   output logic [1:0]        occ,
   output logic              empty,
   output logic [DATA_W-1:0] head_data,
   output logic [IDX_W-1:0]  head_index
);
   import fft_pkg::*;

   logic [DATA_W-1:0] data0;
   logic [DATA_W-1:0] data1;
   logic [IDX_W-1:0]  idx0;
   logic [IDX_W-1:0]  idx1;

   // Callers only pop a non-empty FIFO and never push into a full one.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         occ   <= 2'd0;
         data0 <= '0;
         data1 <= '0;
         idx0  <= '0;
         idx1  <= '0;
      end else begin
         assert (!(push && occ == 2'd2));
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  data0 <= push_data;
                  idx0  <= push_index;
               end else begin
                  data1 <= push_data;
                  idx1  <= push_index;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               data0 <= data1;
               idx0  <= idx1;
               occ   <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  data0 <= push_data;
                  idx0  <= push_index;
               end else begin
                  data0 <= data1;
                  idx0  <= idx1;
                  data1 <= push_data;
                  idx1  <= push_index;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign empty      = (occ == 2'd0);
   assign head_data  = data0;
   assign head_index = idx0;

endmodule

// File: rtl/fft_result_reader.sv
// Unloads the finished spectrum from the two coefficient banks and streams it
// out in natural (or bit-reversed) index order with ready/valid backpressure.
module fft_result_reader #(
   parameter int N_LOG2     = fft_pkg::N_LOG2,
   parameter int DW         = fft_pkg::DW,
   parameter bit BITREV_OUT = 1'b0
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              re_b0,
   output logic [N_LOG2-2:0] raddr_b0,
   output logic              re_b1,
   output logic [N_LOG2-2:0] raddr_b1,
   input  logic [DW-1:0]     rdata_b0,
   input  logic [DW-1:0]     rdata_b1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
   output logic [N_LOG2-1:0] out_index,
   output logic              out_last
);
   import fft_pkg::*;

   localparam logic [N_LOG2-1:0] K_LAST = '1;

   fft_rd_state_e     state;
   fft_rd_state_e     state_next;
   logic [N_LOG2-1:0] issue_cnt;
   logic [N_LOG2-1:0] addr;
   logic [N_LOG2-2:0] row;
   logic              bank;
   logic              issue;
   logic              pop;
   logic              inflight;
   logic              rd_bank;
   logic [N_LOG2-1:0] rd_k;
   logic [1:0]        occ;
   logic              fifo_empty;

   assign addr = BITREV_OUT ? bitrev(issue_cnt) : issue_cnt;
   assign bank = bank_of(addr);
   assign row  = addr[N_LOG2-1:1];
   assign pop  = out_valid & out_ready;

   // A read is only issued when its data is guaranteed a FIFO slot on return,
   // so a stalled consumer stops issue in the very same cycle.
   assign issue = (state == ST_READ) &&
                  (({1'b0, occ} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop}));

   assign re_b0    = issue & ~bank;
   assign re_b1    = issue & bank;
   assign raddr_b0 = re_b0 ? row : '0;
   assign raddr_b1 = re_b1 ? row : '0;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state     <= ST_IDLE;
         issue_cnt <= '0;
         inflight  <= 1'b0;
         rd_bank   <= 1'b0;
         rd_k      <= '0;
      end else begin
         state    <= state_next;
         inflight <= issue;
         if (state == ST_IDLE) begin
            issue_cnt <= '0;
         end else if (issue) begin
            issue_cnt <= issue_cnt + 1'b1;
            rd_bank   <= bank;
            rd_k      <= issue_cnt;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = ST_READ;
         ST_READ:  if (issue && issue_cnt == K_LAST) state_next = ST_DRAIN;
         ST_DRAIN: if (fifo_empty && !inflight) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   fft_out_fifo #(
      .DATA_W (DW),
      .IDX_W  (N_LOG2)
   ) u_fifo (
      .clk        (clk),
      .nrst       (nrst),
      .push       (inflight),
      .push_data  (rd_bank ? rdata_b1 : rdata_b0),
      .push_index (rd_k),
      .pop        (pop),
      .occ        (occ),
      .empty      (fifo_empty),
      .head_data  (out_data),
      .head_index (out_index)
   );

   assign out_valid = ~fifo_empty;
   assign out_last  = out_valid && (out_index == K_LAST);

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader: natural and bit-reversed instances share
// stimulus and read from identical bank models where address a holds a*3.
module tb_fft_result_reader;

   localparam int NL = 6;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          start = 1'b0;
   logic          out_ready = 1'b0;

   logic          busy, done, re_b0, re_b1, out_valid, out_last;
   logic [NL-2:0] raddr_b0, raddr_b1;
   logic [DW-1:0] rdata_b0 = '0, rdata_b1 = '0, out_data;
   logic [NL-1:0] out_index;

   logic          br_busy, br_done, br_re_b0, br_re_b1, br_out_valid, br_out_last;
   logic [NL-2:0] br_raddr_b0, br_raddr_b1;
   logic [DW-1:0] br_rdata_b0 = '0, br_rdata_b1 = '0, br_out_data;
   logic [NL-1:0] br_out_index;

   logic [DW-1:0] mem0 [32];
   logic [DW-1:0] mem1 [32];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fft_result_reader #(.N_LOG2(NL), .DW(DW), .BITREV_OUT(1'b0)) dut (
      .clk(clk), .nrst(nrst), .start(start), .busy(busy), .done(done),
      .re_b0(re_b0), .raddr_b0(raddr_b0), .re_b1(re_b1), .raddr_b1(raddr_b1),
      .rdata_b0(rdata_b0), .rdata_b1(rdata_b1),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last)
   );

   fft_result_reader #(.N_LOG2(NL), .DW(DW), .BITREV_OUT(1'b1)) dut_br (
      .clk(clk), .nrst(nrst), .start(start), .busy(br_busy), .done(br_done),
      .re_b0(br_re_b0), .raddr_b0(br_raddr_b0), .re_b1(br_re_b1), .raddr_b1(br_raddr_b1),
      .rdata_b0(br_rdata_b0), .rdata_b1(br_rdata_b1),
      .out_valid(br_out_valid), .out_ready(out_ready), .out_data(br_out_data),
      .out_index(br_out_index), .out_last(br_out_last)
   );

   // Single-read-port banks with one cycle of read latency.
   always @(posedge clk) begin
      if (re_b0)    rdata_b0    <= mem0[raddr_b0];
      if (re_b1)    rdata_b1    <= mem1[raddr_b1];
      if (br_re_b0) br_rdata_b0 <= mem0[br_raddr_b0];
      if (br_re_b1) br_rdata_b1 <= mem1[br_raddr_b1];
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Inputs change at the falling edge; outputs are sampled 1ns later.
   task automatic applyStimulus(input logic s, input logic r, input logic n);
      @(negedge clk);
      start     = s;
      out_ready = r;
      nrst      = n;
      #1;
   endtask

   // Follows one unload to its done pulse, checking order, hold-while-stalled
   // and how many reads are outstanding at once.
   task automatic streamCheck(input int mode, input int budget, input string tag,
                              input int restartAt, input int preIssued);
      int   nOut = 0;
      int   nDone = 0;
      int   issued = preIssued;
      int   maxOut = 0;
      int   cyc = 0;
      bit   fin = 0;
      logic rdy;
      logic prevStall = 1'b0;
      logic [DW-1:0] prevData = '0;
      logic [NL-1:0] prevIdx = '0;
      logic prevLast = 1'b0;
      while (!fin && cyc < budget) begin
         if (mode == 0)     rdy = 1'b1;
         else if (cyc == 0) rdy = 1'b1;
         else if (cyc < 3)  rdy = 1'b0;
         else               rdy = 1'($urandom_range(0, 1));
         cyc++;
         applyStimulus(logic'(cyc == restartAt), rdy, 1'b1);
         if (prevStall)
            checkOutput({tag, "_hold"}, {out_valid, out_last, out_index, out_data},
                        {1'b1, prevLast, prevIdx, prevData});
         if (issued - nOut > maxOut) maxOut = issued - nOut;
         if (out_valid && out_ready) begin
            checkOutput({tag, "_seq"}, {out_last, out_index, out_data},
                        {logic'(nOut == 63), 6'(nOut), 32'(3 * nOut)});
            nOut++;
         end
         if (re_b0 || re_b1) issued++;
         prevStall = out_valid && !out_ready;
         prevData  = out_data;
         prevIdx   = out_index;
         prevLast  = out_last;
         if (done) begin
            nDone++;
            fin = 1;
         end
      end
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput({tag, "_busy_low"}, busy, 0);
      checkOutput({tag, "_count"}, nOut, 64);
      checkOutput({tag, "_done_count"}, nDone, 1);
      checkOutput({tag, "_outstanding"}, logic'(maxOut <= 2), 1);
   endtask

   initial begin
      logic [NL-1:0] a;
      for (int i = 0; i < 64; i++) begin
         a = 6'(i);
         if (^a) mem1[a[5:1]] = 32'(3 * i);
         else    mem0[a[5:1]] = 32'(3 * i);
      end

      // Reset state
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("reset_all",
                  {busy, done, out_valid, out_last, re_b0, re_b1, raddr_b0, raddr_b1, out_index, out_data}, 0);
      checkOutput("br_reset_all",
                  {br_busy, br_done, br_out_valid, br_re_b0, br_re_b1, br_out_index, br_out_data}, 0);
      applyStimulus(1'b0, 1'b1, 1'b1);

      // Natural order, ready always high, cycle-exact
      applyStimulus(1'b1, 1'b1, 1'b1);
      for (int c = 1; c <= 69; c++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         case (c)
            1: begin
               checkOutput("issue_k0", {re_b0, raddr_b0, re_b1, raddr_b1}, {1'b1, 5'd0, 1'b0, 5'd0});
               checkOutput("busy_rise", busy, 1);
               checkOutput("br_issue_k0", {br_re_b0, br_raddr_b0, br_re_b1, br_raddr_b1}, {1'b1, 5'd0, 1'b0, 5'd0});
            end
            2: begin
               checkOutput("issue_k1", {re_b0, raddr_b0, re_b1, raddr_b1}, {1'b0, 5'd0, 1'b1, 5'd0});
               checkOutput("br_issue_k1", {br_re_b0, br_raddr_b0, br_re_b1, br_raddr_b1}, {1'b0, 5'd0, 1'b1, 5'd16});
            end
            3: checkOutput("issue_k2", {re_b0, raddr_b0, re_b1, raddr_b1}, {1'b0, 5'd0, 1'b1, 5'd1});
            4: begin
               checkOutput("issue_k3", {re_b0, raddr_b0, re_b1, raddr_b1}, {1'b1, 5'd1, 1'b0, 5'd0});
               checkOutput("br_k1_data", {br_out_valid, br_out_index, br_out_data}, {1'b1, 6'd1, 32'd96});
            end
            68: checkOutput("busy_at_done", busy, 1);
            69: checkOutput("busy_fall", busy, 0);
            default: begin
            end
         endcase
         if (c >= 3 && c <= 66)
            checkOutput("nat_stream", {out_valid, out_last, out_index, out_data},
                        {1'b1, logic'(c == 66), 6'(c - 3), 32'(3 * (c - 3))});
         else
            checkOutput("nat_valid_low", out_valid, 0);
         checkOutput("nat_done", done, logic'(c == 68));
      end

      // Backpressure with pseudo-random ready
      applyStimulus(1'b1, 1'b1, 1'b1);
      streamCheck(1, 600, "bp", -1, 0);

      // Second start while busy is ignored
      applyStimulus(1'b1, 1'b1, 1'b1);
      streamCheck(0, 200, "sb", 10, 0);

      // Reset mid-stream then restart from k = 0
      applyStimulus(1'b1, 1'b1, 1'b1);
      for (int c = 1; c <= 22; c++) applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("mid_sample20", {out_valid, out_index}, {1'b1, 6'd20});
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("mid_reset_all",
                  {busy, done, out_valid, out_last, re_b0, re_b1, raddr_b0, raddr_b1, out_index, out_data}, 0);
      checkOutput("br_mid_reset_all",
                  {br_busy, br_done, br_out_valid, br_out_last, br_re_b0, br_re_b1, br_out_index, br_out_data}, 0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      streamCheck(0, 200, "rs", -1, 0);

      // Ready low from start: two samples buffered, issue stops at 2
      applyStimulus(1'b1, 1'b0, 1'b1);
      for (int c = 1; c <= 5; c++) applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("rl_head", {out_valid, out_index, out_data}, {1'b1, 6'd0, 32'd0});
      checkOutput("rl_no_issue", {re_b0, re_b1}, 0);
      checkOutput("rl_issue_cnt", dut.issue_cnt, 2);
      streamCheck(0, 200, "rl", -1, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
